// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// The segment table is stored active-high; polarity is applied at the output registers.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        DRIVE
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int NIB_W      = 4;
    localparam int VAL_W      = NUM_DIGITS * NIB_W;

    // Segment bit order is {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_lookup(input logic [NIB_W-1:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
// A blanked digit lights no segments regardless of its nibble.
module hex_seg_decoder
    import hex_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    assign seg = blank ? '0 : seg_lookup(nibble);

endmodule

// File: rtl/hex_display_scan_ctrl.sv
// Scans a 16-bit hex value onto four multiplexed seven-segment digits with a blanked
// guard interval at the start of each slot; the value is captured once per frame.
module hex_display_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [VAL_W-1:0] value_in,
    input  logic [3:0]       dp_in,
    input  logic             blank_lz,
    output logic [SEG_W-1:0] seg_out,
    output logic             dp_out,
    output logic [3:0]       digit_sel,
    output logic             frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam state_e           SLOT_START = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
    localparam logic [SEG_W-1:0] SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic             DP_OFF     = SEG_ACTIVE_LOW;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc;
    logic [VAL_W-1:0]        shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NIB_W-1:0]        cur_nibble;
    logic                    cur_blank;
    logic [SEG_W-1:0]        seg_raw;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        cnt_inc      = cnt_q + 1'b1;

        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d      = SLOT_START;
                    idx_d        = '0;
                    cnt_d        = '0;
                    shadow_val_d = value_in;
                    shadow_dp_d  = dp_in;
                end
                GUARD, DRIVE: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        // Wrapping back to digit 0 starts a new frame.
                        if (idx_q == LAST_IDX) begin
                            shadow_val_d = value_in;
                            shadow_dp_d  = dp_in;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = (int'(cnt_inc) < GUARD_CYCLES) ? GUARD : DRIVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_upper_zero
        assign upper_zero[i] = ~|shadow_val_d[VAL_W-1:i*NIB_W];
    end

    assign cur_nibble = shadow_val_d[idx_d*NIB_W +: NIB_W];
    assign cur_blank  = blank_lz && (idx_d != '0) && upper_zero[idx_d];

    hex_seg_decoder u_seg_decoder (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (seg_raw)
    );

    // Outputs are derived from the next state so the registered pins line up with state_q.
    always_comb begin
        seg_d        = SEG_OFF;
        dp_d         = DP_OFF;
        digit_sel_d  = '0;
        frame_done_d = 1'b0;
        if (state_d == DRIVE) begin
            digit_sel_d[idx_d] = 1'b1;
            seg_d              = seg_raw ^ {SEG_W{SEG_ACTIVE_LOW}};
            dp_d               = shadow_dp_d[idx_d] ^ SEG_ACTIVE_LOW;
            frame_done_d       = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Randomised scoreboard bench for hex_display_scan_ctrl, run with and without a guard interval.
// Expected pin values come from a frame-time model: position in frame selects digit and phase.
module tb_hex_display_scan_ctrl;

    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int FRAME = 4 * SD;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fd;
    } out_t;

    typedef struct {
        bit          run;
        int          t;
        logic [15:0] sv;
        logic [3:0]  sdp;
    } mdl_t;

    localparam logic [6:0] SEG_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset, enable, blank_lz;
    logic [15:0] value_in;
    logic [3:0]  dp_in;

    logic [6:0]  seg_g, seg_n;
    logic        dp_g, dp_n, fd_g, fd_n;
    logic [3:0]  sel_g, sel_n;

    mdl_t        m_g, m_n;
    out_t        q_g[$], q_n[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    hex_display_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYCLES(GD), .SEG_ACTIVE_LOW(1'b1)) u_dut_g (
        .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg_out(seg_g), .dp_out(dp_g), .digit_sel(sel_g), .frame_done(fd_g)
    );

    hex_display_scan_ctrl #(.SCAN_DIV(SD), .GUARD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg_out(seg_n), .dp_out(dp_n), .digit_sel(sel_n), .frame_done(fd_n)
    );

    // Advances the model by one clock edge using the inputs that edge will sample.
    function automatic out_t model_step(inout mdl_t m, input int guard);
        out_t o;
        int   phase, digit;
        logic [3:0] nib;
        bit   blank;
        o = '{seg: 7'h7F, dp: 1'b1, sel: 4'b0000, fd: 1'b0};
        if (reset) begin
            m.run = 0; m.t = 0; m.sv = '0; m.sdp = '0;
            return o;
        end
        if (!enable) begin
            m.run = 0; m.t = 0;
            return o;
        end
        if (!m.run) begin
            m.run = 1; m.t = 0;
        end else begin
            m.t = (m.t + 1) % FRAME;
        end
        if (m.t == 0) begin
            m.sv = value_in; m.sdp = dp_in;
        end
        phase = m.t % SD;
        digit = m.t / SD;
        if (phase < guard) return o;
        nib   = 4'((m.sv >> (4 * digit)) & 16'hF);
        blank = blank_lz && (digit >= 1) && ((m.sv >> (4 * digit)) == 16'h0);
        o.sel = 4'(1 << digit);
        o.seg = blank ? 7'h7F : ~SEG_HI[nib];
        o.dp  = ~m.sdp[digit];
        o.fd  = (digit == 3) && (phase == SD - 1);
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got seg=%h dp=%b sel=%b fd=%b, want seg=%h dp=%b sel=%b fd=%b",
                     name, $time, act.seg, act.dp, act.sel, act.fd, exp.seg, exp.dp, exp.sel, exp.fd);
        end
    endtask

    // Called at a falling edge: queue expectations for the next rising edge, then wait it out.
    task automatic step();
        q_g.push_back(model_step(m_g, GD));
        q_n.push_back(model_step(m_n, 0));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Runs until the guarded model sits at the given frame position, with a cycle budget.
    task automatic run_until(input int target);
        bit hit = 0;
        for (int k = 0; k < 2 * FRAME && !hit; k++) begin
            if (m_g.run && m_g.t == target) hit = 1;
            else step();
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL run_until: frame position %0d not reached within budget", target);
        end
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (q_g.size() > 0) check("guard2", '{seg: seg_g, dp: dp_g, sel: sel_g, fd: fd_g}, q_g.pop_front());
        if (q_n.size() > 0) check("guard0", '{seg: seg_n, dp: dp_n, sel: sel_n, fd: fd_n}, q_n.pop_front());
    end

    initial begin
        reset = 1'b1; enable = 1'b0; blank_lz = 1'b0; value_in = 16'h0; dp_in = 4'h0;
        m_g = '{run: 0, t: 0, sv: '0, sdp: '0};
        m_n = m_g;
        @(negedge clk);
        run(3);

        // Basic scan of 12AF for two frames.
        reset = 1'b0; enable = 1'b1; value_in = 16'h12AF;
        run(2 * FRAME);

        // Mid-frame value change during digit 1 drive must wait for the next frame.
        run_until(SD + 4);
        value_in = 16'h0000;
        run(FRAME + SD);

        // Leading-zero blanking with a decimal point on a blanked digit.
        blank_lz = 1'b1; value_in = 16'h0050; dp_in = 4'b1000;
        run(2 * FRAME);

        // Enable drop during digit 2 drive, then re-enable with a new value.
        run_until(2 * SD + 4);
        enable = 1'b0;
        run(3);
        enable = 1'b1; value_in = 16'hC0DE; dp_in = 4'b0101; blank_lz = 1'b0;
        run(FRAME + 4);

        // One-cycle reset mid-frame with enable held high.
        run_until(SD + 5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(FRAME + 4);

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 9) == 0) value_in = rand_value();
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            step();
        end

        for (int k = 0; k < 4 && (q_g.size() > 0 || q_n.size() > 0); k++) @(negedge clk);
        n_tests++;
        if (q_g.size() > 0 || q_n.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left unchecked", q_g.size(), q_n.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_scan_ctrl.md
Name: hex_display_scan_ctrl

Overview:
- Time-multiplexes the 16-bit hex value held by the SoC hex-digits PIO onto four common-anode seven-segment digits that share one segment bus.
- Sequences digit select, segment drive and anti-ghosting guard intervals.
- Latches the value only at frame boundaries so a digit never tears mid-frame.
- Sits between the PIO out_port and the board's HEX pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (guard plus drive); must be >= 2.
- GUARD_CYCLES, 500, blanked cycles at the start of each slot; must be < SCAN_DIV; 0 means no guard.
- SEG_ACTIVE_LOW, 1, 1 = seg_out and dp_out asserted low; digit_sel is always active-high one-hot.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning enabled; low forces IDLE.
- value_in  in  16  hex value; nibble i drives digit i (digit 0 = [3:0], rightmost).
- dp_in  in  4  decimal point per digit; bit i is digit i.
- blank_lz  in  1  blank leading-zero digits.
- seg_out  out  7  segments {g,f,e,d,c,b,a}.
- dp_out  out  1  decimal point.
- digit_sel  out  4  one-hot digit enable.
- frame_done  out  1  one-cycle pulse at end of each full frame.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset, sampled on the rising edge of clk.
- All outputs are registered.
- Reset values:
  - state IDLE, digit index 0, slot counter 0.
  - Shadow value and shadow dp = 0.
  - digit_sel = 0, frame_done = 0.
  - seg_out all off (7'h7F when SEG_ACTIVE_LOW, else 7'h00); dp_out off.
- States:
  - IDLE: outputs off. If enable is sampled high, go to GUARD for digit 0; go straight to DRIVE if GUARD_CYCLES = 0.
  - GUARD: digit_sel = 0, segments off. Lasts GUARD_CYCLES cycles, then DRIVE.
  - DRIVE: digit_sel = one-hot(idx); seg_out and dp_out come from the shadow nibble and dp bit for idx. Lasts SCAN_DIV - GUARD_CYCLES cycles. Then idx = idx + 1 mod 4 and return to GUARD (or DRIVE if there is no guard).
- Frame:
  - One frame is 4*SCAN_DIV cycles.
  - Shadow value and dp are latched from value_in/dp_in on the edge that enters digit 0's first slot cycle, both from IDLE and on the idx 3->0 wrap.
  - Mid-frame changes to value_in are ignored until the next frame.
- frame_done: high for exactly one cycle, coincident with the last DRIVE cycle of digit 3.
- Leading-zero blanking: with blank_lz = 1, digit i (i >= 1) is blanked (segments off) when shadow nibbles i..3 are all zero. Digit 0 is never blanked. dp is still driven on blanked digits.
- Segment map (active-high form), then inverted when SEG_ACTIVE_LOW:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07.
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
- enable deasserted in any state: the next edge enters IDLE with outputs off and idx/counter cleared. Re-enable restarts at digit 0 and relatches the shadow.
- reset asserted mid-frame: identical to the reset values on the next edge; reset overrides enable.
- Counter width is $clog2(SCAN_DIV); it wraps without overflow because it is cleared at every slot boundary.

Decomposition:
- Package hex_disp_pkg:
  - state enum {IDLE, GUARD, DRIVE}.
  - NUM_DIGITS = 4, SEG_W = 7.
  - 16-entry active-high segment table constant.
- Sub-module hex_seg_decoder: combinational nibble + blank -> 7-bit active-high segments.
- Polarity inversion and output registering stay in the parent.

Test Plan (SCAN_DIV = 8, GUARD_CYCLES = 2, SEG_ACTIVE_LOW = 1):
- Reset then enable = 1, value_in = 16'h12AF -> each slot gives 2 cycles digit_sel = 0 and seg 7F, then 6 cycles of:
  - digit_sel 0001, seg 0E (F);
  - 0010, 08 (A);
  - 0100, 24 (2);
  - 1000, 79 (1).
  - frame_done pulses every 32 cycles.
- Change value_in 16'h12AF -> 16'h0000 during digit 1 DRIVE -> digits 2 and 3 still show 2 and 1; the next frame shows 40 on all digits.
- blank_lz = 1, value_in = 16'h0050, dp_in = 4'b1000 -> digit 0 seg 40, digit 1 seg 12, digit 2 seg 7F, digit 3 seg 7F with dp_out = 0.
- enable dropped during digit 2 DRIVE -> next cycle digit_sel = 0, seg 7F, no frame_done. Re-enable -> digit 0 GUARD with the value relatched.
- reset pulsed for 1 cycle mid-frame with enable held high -> next cycle all outputs at reset values, then the frame restarts at digit 0.
- GUARD_CYCLES = 0 build -> digit_sel never 0 while enabled, each digit is driven for 8 cycles, and frame_done period is 32.
